// File: rtl/dmem_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_lsu_pkg
// Purpose : Shared access-size codes, LSU state encoding and the
//           word-boundary crossing test used by the data-memory load/store
//           unit.
// Contents: DMEM_EXT_* size codes, lsu_state_e, crosses_word().
// Revision: 1.0 - initial release
// ============================================================================
package dmem_lsu_pkg;

  // Access size codes: number of bytes is 1 << code
  localparam logic [1:0] DMEM_EXT_BYTE  = 2'd0;
  localparam logic [1:0] DMEM_EXT_HALF  = 2'd1;
  localparam logic [1:0] DMEM_EXT_WORD  = 2'd2;
  localparam logic [1:0] DMEM_EXT_DWORD = 2'd3;

  typedef enum logic [2:0] {
    LSU_IDLE  = 3'd0,
    LSU_ACC0  = 3'd1,
    LSU_WAIT0 = 3'd2,
    LSU_ACC1  = 3'd3,
    LSU_WAIT1 = 3'd4,
    LSU_ERR   = 3'd5,
    LSU_RESP  = 3'd6
  } lsu_state_e;

  // True when an access of the given size starting at byte offset 'off'
  // runs past the end of a BYTES-wide memory word.
  function automatic logic crosses_word(input logic [31:0] off,
                                        input logic [1:0]  size,
                                        input int unsigned bytes);
    return (off + (32'd1 << size)) > bytes;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lsu_align.sv
`default_nettype none
// ============================================================================
// Module  : lsu_align
// Purpose : Combinational lane logic for the load/store unit. Builds the
//           byte enables and write-data lanes for both beats of an access
//           and merges/extends load data from up to two memory words.
// Ports   : size, unsign, off      - latched access attributes
//           wdata                  - LSB-aligned store data
//           rdata0, rdata1         - captured read words for beat 0 / beat 1
//           be0, be1               - byte enables for beat 0 / beat 1
//           wdata0, wdata1         - lane-shifted store data per beat
//           rdata                  - aligned, extended load result
// Revision: 1.0 - initial release
// ============================================================================
module lsu_align #(
  parameter int XLEN = 32
) (
  input  logic [1:0]                  size,
  input  logic                        unsign,
  input  logic [$clog2(XLEN/8)-1:0]   off,
  input  logic [XLEN-1:0]             wdata,
  input  logic [XLEN-1:0]             rdata0,
  input  logic [XLEN-1:0]             rdata1,
  output logic [XLEN/8-1:0]           be0,
  output logic [XLEN/8-1:0]           be1,
  output logic [XLEN-1:0]             wdata0,
  output logic [XLEN-1:0]             wdata1,
  output logic [XLEN-1:0]             rdata
);

  localparam int BYTES = XLEN / 8;

  logic [2*BYTES-1:0] len_mask;
  logic [2*BYTES-1:0] be_wide;
  logic [2*XLEN-1:0]  wd_wide;
  logic [XLEN-1:0]    raw;
  logic [XLEN-1:0]    keep_mask;
  logic               sign;

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < 2*BYTES; i++) begin
      if (i < (1 << size)) len_mask[i] = 1'b1;
    end

    // Mask spans two words so the bits pushed past BYTES become beat 1
    be_wide = len_mask << off;
    be0     = be_wide[BYTES-1:0];
    be1     = be_wide[2*BYTES-1:BYTES];

    // Upper half of the double-width shift is exactly wdata >> 8*(BYTES-off)
    wd_wide = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
    wdata0  = wd_wide[XLEN-1:0];
    wdata1  = wd_wide[2*XLEN-1:XLEN];

    raw = XLEN'({rdata1, rdata0} >> {off, 3'b000});

    keep_mask = '0;
    for (int i = 0; i < XLEN; i++) begin
      keep_mask[i] = len_mask[i/8];
    end

    case (size)
      2'd0:    sign = raw[7];
      2'd1:    sign = raw[15];
      2'd2:    sign = raw[31];
      default: sign = raw[XLEN-1];
    endcase

    rdata = (raw & keep_mask) | ((sign && !unsign) ? ~keep_mask : '0);
  end

endmodule
`default_nettype wire

// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module  : dmem_lsu
// Purpose : Registered, handshaked load/store unit between the core and a
//           synchronous byte-enabled data memory. One request at a time,
//           one response pulse per request; word-crossing accesses are
//           split into two beats or reported as errors.
// Ports   : clk, rst (async, active-low)
//           req_*  - request handshake and attributes from the core
//           rsp_*  - one-cycle response pulse, load data, error flag
//           mem_*  - memory request/grant, word index, byte enables, data
// Revision: 1.0 - initial release
// ============================================================================
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int AWIDTH         = 16,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic                               req_we,
  input  logic [1:0]                         req_size,
  input  logic                               req_unsign,
  input  logic [AWIDTH-1:0]                  req_addr,
  input  logic [XLEN-1:0]                    req_wdata,
  output logic                               rsp_valid,
  output logic [XLEN-1:0]                    rsp_rdata,
  output logic                               rsp_err,
  output logic                               mem_req,
  input  logic                               mem_gnt,
  output logic [AWIDTH-$clog2(XLEN/8)-1:0]   mem_addr,
  output logic [XLEN/8-1:0]                  mem_be,
  output logic [XLEN-1:0]                    mem_wdata,
  input  logic [XLEN-1:0]                    mem_rdata
);

  localparam int BYTES  = XLEN / 8;
  localparam int BSH    = $clog2(BYTES);
  localparam int IWIDTH = AWIDTH - BSH;

  lsu_state_e        state;
  logic              ready;
  logic              we_q;
  logic [1:0]        size_q;
  logic              unsign_q;
  logic [AWIDTH-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic              split_q;
  logic [XLEN-1:0]   rdata0_q;
  logic [XLEN-1:0]   rdata1_q;

  logic              illegal_in;
  logic              cross_in;
  logic [IWIDTH-1:0] idx;
  logic [IWIDTH-1:0] idx_next;
  logic [BYTES-1:0]  be0, be1;
  logic [XLEN-1:0]   wdata0, wdata1, merged;

  assign illegal_in = (XLEN == 32) && (req_size == DMEM_EXT_DWORD);
  assign cross_in   = crosses_word(32'(req_addr[BSH-1:0]), req_size, BYTES);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= LSU_IDLE;
      ready    <= 1'b0;
      we_q     <= 1'b0;
      size_q   <= '0;
      unsign_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      split_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      // ready is registered so it reads 0 throughout reset and only rises
      // on the edge that lands the FSM in IDLE
      ready <= 1'b0;
      case (state)
        LSU_IDLE: begin
          if (req_valid && ready) begin
            we_q     <= req_we;
            size_q   <= req_size;
            unsign_q <= req_unsign;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            rdata0_q <= '0;
            // Single-beat loads merge against zero in the upper word
            rdata1_q <= '0;
            split_q  <= cross_in;
            if (illegal_in || (cross_in && !MISALIGN_SPLIT)) state <= LSU_ERR;
            else                                             state <= LSU_ACC0;
          end else begin
            ready <= 1'b1;
          end
        end
        LSU_ACC0: begin
          if (mem_gnt) begin
            if (!we_q)       state <= LSU_WAIT0;
            else if (split_q) state <= LSU_ACC1;
            else             state <= LSU_RESP;
          end
        end
        LSU_WAIT0: begin
          rdata0_q <= mem_rdata;
          state    <= split_q ? LSU_ACC1 : LSU_RESP;
        end
        LSU_ACC1: begin
          if (mem_gnt) state <= we_q ? LSU_RESP : LSU_WAIT1;
        end
        LSU_WAIT1: begin
          rdata1_q <= mem_rdata;
          state    <= LSU_RESP;
        end
        LSU_ERR, LSU_RESP: begin
          ready <= 1'b1;
          state <= LSU_IDLE;
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .size   (size_q),
    .unsign (unsign_q),
    .off    (addr_q[BSH-1:0]),
    .wdata  (wdata_q),
    .rdata0 (rdata0_q),
    .rdata1 (rdata1_q),
    .be0    (be0),
    .be1    (be1),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .rdata  (merged)
  );

  assign idx      = addr_q[AWIDTH-1:BSH];
  // Natural wrap of the index width sends the top word's successor to 0
  assign idx_next = idx + {{(IWIDTH-1){1'b0}}, 1'b1};

  assign req_ready = ready;
  assign mem_req   = (state == LSU_ACC0) || (state == LSU_ACC1);
  assign mem_addr  = (state == LSU_ACC0) ? idx :
                     (state == LSU_ACC1) ? idx_next : '0;
  assign mem_be    = (we_q && state == LSU_ACC0) ? be0 :
                     (we_q && state == LSU_ACC1) ? be1 : '0;
  assign mem_wdata = (we_q && state == LSU_ACC0) ? wdata0 :
                     (we_q && state == LSU_ACC1) ? wdata1 : '0;
  assign rsp_valid = (state == LSU_RESP) || (state == LSU_ERR);
  assign rsp_err   = (state == LSU_ERR);
  assign rsp_rdata = (state == LSU_RESP && !we_q) ? merged : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_lsu
// Purpose : Scoreboard bench for dmem_lsu (XLEN=32, AWIDTH=16). Instance
//           dut splits misaligned accesses; instance dut_ns reports them as
//           errors. A memory model answers dut's beats.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_lsu;
  import dmem_lsu_pkg::*;

  typedef struct {
    logic [13:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        req_valid = 1'b0, req_we = 1'b0, req_unsign = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [15:0] req_addr = 16'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready, rsp_valid, rsp_err, mem_req;
  logic [31:0] rsp_rdata, mem_wdata;
  logic [13:0] mem_addr;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b1;
  logic [31:0] mem_rdata = 32'd0;

  logic        b_req_valid = 1'b0;
  logic [1:0]  b_req_size = 2'd0;
  logic [15:0] b_req_addr = 16'd0;
  logic        b_req_ready, b_rsp_valid, b_rsp_err, b_mem_req;
  logic [31:0] b_rsp_rdata, b_mem_wdata;
  logic [13:0] b_mem_addr;
  logic [3:0]  b_mem_be;

  beat_t       beat_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] mem [int];
  int          checks = 0, failures = 0, cyc = 0;
  logic        rd_pend = 1'b0;
  logic [31:0] rd_val = 32'd0;
  logic        b_saw_req = 1'b0;

  dmem_lsu #(.XLEN(32), .AWIDTH(16), .MISALIGN_SPLIT(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsign(req_unsign), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_req(mem_req), .mem_gnt(mem_gnt),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  dmem_lsu #(.XLEN(32), .AWIDTH(16), .MISALIGN_SPLIT(1'b0)) dut_ns (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(1'b0),
    .req_size(b_req_size), .req_unsign(1'b0), .req_addr(b_req_addr),
    .req_wdata(32'd0), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .mem_req(b_mem_req), .mem_gnt(1'b1),
    .mem_addr(b_mem_addr), .mem_be(b_mem_be), .mem_wdata(b_mem_wdata),
    .mem_rdata(32'd0)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // Read data is only valid in the cycle after the granted read
  initial forever begin
    @(posedge clk);
    #1;
    if (rd_pend) begin mem_rdata = rd_val; rd_pend = 1'b0; end
    else mem_rdata = 32'hDEAD_BEEF;
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: memory beats and responses of dut, checked against queues
  initial begin
    beat_t b;
    rsp_t  r;
    int    a;
    logic [31:0] w;
    forever begin
      @(negedge clk);
      if (b_mem_req) b_saw_req = 1'b1;
      if (mem_req && mem_gnt) begin
        a = int'(mem_addr);
        if (beat_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL beat_unexpected: actual addr=%h be=%b required=no beat", mem_addr, mem_be);
        end else begin
          b = beat_q.pop_front();
          check32("beat_addr", 32'(mem_addr), 32'(b.addr));
          check32("beat_be", 32'(mem_be), 32'(b.be));
          if (b.be != 4'd0) check32("beat_wdata", mem_wdata, b.wdata);
        end
        w = mem.exists(a) ? mem[a] : 32'd0;
        if (mem_be != 4'd0) begin
          for (int i = 0; i < 4; i++) if (mem_be[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
          mem[a] = w;
        end else begin
          rd_val  = w;
          rd_pend = 1'b1;
        end
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rsp_unexpected: actual rdata=%h err=%b required=no response", rsp_rdata, rsp_err);
        end else begin
          r = rsp_q.pop_front();
          check32("rsp_rdata", rsp_rdata, r.rdata);
          check32("rsp_err", 32'(rsp_err), 32'(r.err));
          check32("rsp_cycle", 32'(cyc), 32'(r.cyc));
        end
      end
    end
  end

  task automatic push_beat(input logic [13:0] addr, input logic [3:0] be, input logic [31:0] wd);
    beat_t b;
    b.addr = addr; b.be = be; b.wdata = wd;
    beat_q.push_back(b);
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [15:0] addr, input logic [31:0] wd, input int lat,
                       input logic [31:0] exp_rd, input logic exp_err, input bit expect_rsp);
    int   t = 0;
    rsp_t r;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsign = uns;
    req_addr = addr; req_wdata = wd;
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout: actual ready=0 required=1");
    end
    if (expect_rsp) begin
      r.rdata = exp_rd; r.err = exp_err; r.cyc = cyc + lat;
      rsp_q.push_back(r);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while ((rsp_q.size() != 0 || beat_q.size() != 0) && t < 40) begin
      @(posedge clk); t++;
    end
    check32({name, "_drained"}, 32'(rsp_q.size() + beat_q.size()), 32'd0);
  endtask

  task automatic b_issue(input logic [15:0] addr, input logic [1:0] size);
    int t = 0;
    @(negedge clk);
    b_req_valid = 1'b1; b_req_addr = addr; b_req_size = size;
    while (!b_req_ready && t < 20) begin @(negedge clk); t++; end
    check32("b_accept_ready", 32'(b_req_ready), 32'd1);
    @(posedge clk);
    #1 b_req_valid = 1'b0;
    @(negedge clk);
    check32("b_rsp_valid", 32'(b_rsp_valid), 32'd1);
    check32("b_rsp_err", 32'(b_rsp_err), 32'd1);
    check32("b_rsp_rdata", b_rsp_rdata, 32'd0);
    @(negedge clk);
    check32("b_rsp_pulse_end", 32'(b_rsp_valid), 32'd0);
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check32("reset_ready", 32'(req_ready), 32'd0);
    check32("reset_mem_req", 32'(mem_req), 32'd0);
    check32("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check32("reset_mem_be", 32'(mem_be), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check32("ready_after_reset", 32'(req_ready), 32'd1);

    // Byte loads, signed and unsigned, from the top byte of 0x80FF_1234
    mem[0] = 32'h80FF_1234;
    push_beat(14'd0, 4'd0, 32'd0);
    issue(1'b0, DMEM_EXT_BYTE, 1'b0, 16'h0003, 32'd0, 3, 32'hFFFF_FF80, 1'b0, 1'b1);
    wait_done("lb_signed");
    push_beat(14'd0, 4'd0, 32'd0);
    issue(1'b0, DMEM_EXT_BYTE, 1'b1, 16'h0003, 32'd0, 3, 32'h0000_0080, 1'b0, 1'b1);
    wait_done("lb_unsigned");

    // Half store to the upper lanes of word 1, then read it back signed
    push_beat(14'd1, 4'b1100, 32'hBEEF_0000);
    issue(1'b1, DMEM_EXT_HALF, 1'b0, 16'h0006, 32'h0000_BEEF, 2, 32'd0, 1'b0, 1'b1);
    wait_done("sh");
    push_beat(14'd1, 4'd0, 32'd0);
    issue(1'b0, DMEM_EXT_HALF, 1'b0, 16'h0006, 32'd0, 3, 32'hFFFF_BEEF, 1'b0, 1'b1);
    wait_done("lh");

    // Split word load across words 0 and 1
    mem[0] = 32'hAAAA_1111;
    mem[1] = 32'h2222_BBBB;
    push_beat(14'd0, 4'd0, 32'd0);
    push_beat(14'd1, 4'd0, 32'd0);
    issue(1'b0, DMEM_EXT_WORD, 1'b0, 16'h0002, 32'd0, 5, 32'hBBBB_AAAA, 1'b0, 1'b1);
    wait_done("lw_split");

    // Split store at the top word wraps beat 1 to index 0; read it back
    push_beat(14'h3FFF, 4'b1100, 32'h5678_0000);
    push_beat(14'h0000, 4'b0011, 32'h0000_1234);
    issue(1'b1, DMEM_EXT_WORD, 1'b0, 16'hFFFE, 32'h1234_5678, 3, 32'd0, 1'b0, 1'b1);
    wait_done("sw_wrap");
    push_beat(14'h3FFF, 4'd0, 32'd0);
    push_beat(14'h0000, 4'd0, 32'd0);
    issue(1'b0, DMEM_EXT_WORD, 1'b0, 16'hFFFE, 32'd0, 5, 32'h1234_5678, 1'b0, 1'b1);
    wait_done("lw_wrap");

    // Doubleword is illegal on a 32-bit unit: error, no memory beat
    issue(1'b0, DMEM_EXT_DWORD, 1'b0, 16'h0000, 32'd0, 1, 32'd0, 1'b1, 1'b1);
    wait_done("dword_illegal");

    // Grant withheld for 4 cycles: request and index must hold
    mem_gnt = 1'b0;
    push_beat(14'd4, 4'b1111, 32'hCAFE_F00D);
    issue(1'b1, DMEM_EXT_WORD, 1'b0, 16'h0010, 32'hCAFE_F00D, 6, 32'd0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check32("stall_mem_req", 32'(mem_req), 32'd1);
      check32("stall_mem_addr", 32'(mem_addr), 32'd4);
    end
    @(posedge clk);
    #2 mem_gnt = 1'b1;
    wait_done("stall");

    // Non-splitting instance reports misaligned and illegal sizes
    b_issue(16'h0002, DMEM_EXT_WORD);
    b_issue(16'h0000, DMEM_EXT_DWORD);
    check32("b_no_mem_req", 32'(b_saw_req), 32'd0);

    // Reset while waiting for read data drops the transaction
    push_beat(14'd0, 4'd0, 32'd0);
    issue(1'b0, DMEM_EXT_WORD, 1'b0, 16'h0000, 32'd0, 0, 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check32("midop_reset_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check32("midop_ready_after", 32'(req_ready), 32'd1);
    repeat (4) @(negedge clk);
    check32("midop_beats_done", 32'(beat_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
